reset_sequencer: RTL and testbench

- Parametrised successor to the top-level power-on reset stretcher; replaces the single fixed 8-bit counter.
- Waits for every PLL lock input to be stably high, then releases NUM_STAGES active-low reset domains in order (e.g. SPI word handler, state machine, drivers), each after its own stretch interval.
- Handles lock loss and the external reset request at runtime; reports a sticky fault and a saturating loss counter to the SPI state machine.

---
 rtl/reset_sequencer.sv | 149 ++++++++++++++
 tb/tb_reset_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Power-on reset sequencer: qualifies PLL lock, then releases NUM_STAGES active-low
// reset domains in ascending order, each after a 2^STRETCH_BITS cycle stretch.
module reset_sequencer #(
  parameter int NUM_STAGES       = 3,
  parameter int STRETCH_BITS     = 8,
  parameter int NUM_LOCKS        = 1,
  parameter int LOCK_FILTER_BITS = 4
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  resetn_in,
  input  logic [NUM_LOCKS-1:0]  pll_locked,
  input  logic                  halt,
  output logic [NUM_STAGES-1:0] stage_resetn,
  output logic                  all_ready,
  output logic                  fault,
  output logic [7:0]            lock_loss_count
);

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [LOCK_FILTER_BITS-1:0] FILT_MAX = '1;
  localparam logic [IDX_W-1:0]            LAST_IDX = IDX_W'(NUM_STAGES - 1);

  // HOLD: external request held | WAIT_LOCK: lock qualify | STRETCH: staged release | RUN: all released
  typedef enum logic [1:0] {HOLD, WAIT_LOCK, STRETCH, RUN} state_e;

  state_e                      state_q, state_d;
  logic [LOCK_FILTER_BITS-1:0] filt_q, filt_d;
  logic                        locks_ok_q, locks_ok_d;
  logic [STRETCH_BITS-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [NUM_STAGES-1:0]       stage_q, stage_d;
  logic                        ready_q, ready_d;
  logic                        fault_q, fault_d;
  logic [7:0]                  count_q, count_d;
  logic                        lock_ok;
  logic                        lost;

  always_comb begin
    lock_ok    = &pll_locked;
    filt_d     = '0;
    if (lock_ok) begin
      filt_d = (filt_q == FILT_MAX) ? FILT_MAX : filt_q + 1'b1;
    end
    // Qualified on the sample that finds the counter already saturated.
    locks_ok_d = lock_ok && (filt_q == FILT_MAX);
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    ready_d = ready_q;
    fault_d = fault_q;
    count_d = count_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    lost    = !lock_ok && ((state_q == STRETCH) || (state_q == RUN));

    if (!resetn_in) begin
      state_d = HOLD;
      stage_d = '0;
      ready_d = 1'b0;
      fault_d = 1'b0;
      idx_d   = '0;
      cnt_d   = '0;
    end else if (lost) begin
      state_d = WAIT_LOCK;
      stage_d = '0;
      ready_d = 1'b0;
      fault_d = 1'b1;
      idx_d   = '0;
      cnt_d   = '0;
      if (count_q != 8'hFF) begin
        count_d = count_q + 8'd1;
      end
    end else begin
      case (state_q)
        HOLD: begin
          stage_d = '0;
          ready_d = 1'b0;
          fault_d = 1'b0;
          state_d = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (locks_ok_q) begin
            state_d = STRETCH;
            idx_d   = '0;
            cnt_d   = '0;
          end
        end
        STRETCH: begin
          if (!halt) begin
            cnt_d = cnt_q + 1'b1;
            if (&cnt_q) begin
              cnt_d = '0;
              for (int k = 0; k < NUM_STAGES; k++) begin
                if (idx_q == IDX_W'(k)) begin
                  stage_d[k] = 1'b1;
                end
              end
              if (idx_q == LAST_IDX) begin
                ready_d = 1'b1;
                state_d = RUN;
                idx_d   = '0;
              end else begin
                idx_d = idx_q + 1'b1;
              end
            end
          end
        end
        RUN: begin
          stage_d = '1;
          ready_d = 1'b1;
        end
        default: state_d = HOLD;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q    <= HOLD;
      filt_q     <= '0;
      locks_ok_q <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= '0;
      stage_q    <= '0;
      ready_q    <= 1'b0;
      fault_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      filt_q     <= filt_d;
      locks_ok_q <= locks_ok_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      stage_q    <= stage_d;
      ready_q    <= ready_d;
      fault_q    <= fault_d;
      count_q    <= count_d;
    end
  end

  assign stage_resetn    = stage_q;
  assign all_ready       = ready_q;
  assign fault           = fault_q;
  assign lock_loss_count = count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: timed expectations queued per cycle, compared after each edge.
module tb_reset_sequencer;

  logic       CLK = 1'b0;
  logic       reset;
  logic       resetn_in;
  logic [1:0] pll_locked;
  logic       halt;
  logic [2:0] stage_resetn;
  logic       all_ready;
  logic       fault;
  logic [7:0] lock_loss_count;

  reset_sequencer #(
    .NUM_STAGES(3), .STRETCH_BITS(4), .NUM_LOCKS(2), .LOCK_FILTER_BITS(2)
  ) dut (
    .CLK(CLK), .reset(reset), .resetn_in(resetn_in), .pll_locked(pll_locked), .halt(halt),
    .stage_resetn(stage_resetn), .all_ready(all_ready), .fault(fault),
    .lock_loss_count(lock_loss_count)
  );

  always #5 CLK = ~CLK;

  typedef struct { int off; logic [2:0] stg; logic rdy; } vec_t;
  typedef struct { int at; string name; logic [2:0] stg; logic rdy; logic flt; logic [7:0] cnt; } exp_t;

  vec_t seq_tbl[8];
  exp_t sbq[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  function automatic void compare(string name, logic [2:0] stg, logic rdy, logic flt, logic [7:0] cnt);
    checks++;
    if (stage_resetn !== stg || all_ready !== rdy || fault !== flt || lock_loss_count !== cnt) begin
      errors++;
      $display("FAIL %s cyc=%0d: got stage=%b ready=%b fault=%b count=%0d, expected stage=%b ready=%b fault=%b count=%0d",
               name, cyc, stage_resetn, all_ready, fault, lock_loss_count, stg, rdy, flt, cnt);
    end
  endfunction

  function automatic void expect_at(int at, string name, logic [2:0] stg, logic rdy, logic flt, logic [7:0] cnt);
    exp_t e;
    int   pos;
    e.at = at; e.name = name; e.stg = stg; e.rdy = rdy; e.flt = flt; e.cnt = cnt;
    pos = sbq.size();
    while (pos > 0 && sbq[pos-1].at > at) pos--;
    sbq.insert(pos, e);
  endfunction

  // e is the edge that enters STRETCH; stage k expected at e + 16*(k+1).
  function automatic void push_seq(int e, logic flt, logic [7:0] cnt, int limit, string tag);
    foreach (seq_tbl[i]) begin
      if (seq_tbl[i].off <= limit) begin
        expect_at(e + seq_tbl[i].off, tag, seq_tbl[i].stg, seq_tbl[i].rdy, flt, cnt);
      end
    end
  endfunction

  task automatic wait_cyc(int t);
    while (cyc < t) @(negedge CLK);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      cyc++;
      #1;
      while (sbq.size() > 0 && sbq[0].at <= cyc) begin
        e = sbq.pop_front();
        if (e.at < cyc) begin
          checks++;
          errors++;
          $display("FAIL %s: slot cyc=%0d missed, now cyc=%0d", e.name, e.at, cyc);
        end else begin
          compare(e.name, e.stg, e.rdy, e.flt, e.cnt);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: cyc=%0d, expected bench to end before this", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int r, ev, n;
    logic [7:0] cexp;

    seq_tbl[0] = '{-1, 3'b000, 1'b0};
    seq_tbl[1] = '{15, 3'b000, 1'b0};
    seq_tbl[2] = '{16, 3'b001, 1'b0};
    seq_tbl[3] = '{31, 3'b001, 1'b0};
    seq_tbl[4] = '{32, 3'b011, 1'b0};
    seq_tbl[5] = '{47, 3'b011, 1'b0};
    seq_tbl[6] = '{48, 3'b111, 1'b1};
    seq_tbl[7] = '{60, 3'b111, 1'b1};

    reset = 1'b1; resetn_in = 1'b1; pll_locked = 2'b11; halt = 1'b0;
    #1;
    compare("reset_state", 3'b000, 1'b0, 1'b0, 8'd0);
    expect_at(2, "reset_held", 3'b000, 1'b0, 1'b0, 8'd0);

    // Power-up sequence: 4 lock samples, then STRETCH on the next edge.
    repeat (3) @(negedge CLK);
    reset = 1'b0;
    r = cyc;
    expect_at(r + 1, "hold_exit", 3'b000, 1'b0, 1'b0, 8'd0);
    push_seq(r + 5, 1'b0, 8'd0, 99, "powerup");
    wait_cyc(r + 5 + 60);

    // External request from RUN, then lock drop at T0+20 during the resequence.
    n = cyc;
    resetn_in = 1'b0;
    expect_at(n + 1, "req_assert", 3'b000, 1'b0, 1'b0, 8'd0);
    expect_at(n + 3, "req_held", 3'b000, 1'b0, 1'b0, 8'd0);
    wait_cyc(n + 3);
    resetn_in = 1'b1;
    ev = n + 5;
    push_seq(ev, 1'b0, 8'd0, 16, "reseq_b");
    wait_cyc(ev + 20);
    pll_locked = 2'b01;
    expect_at(ev + 21, "lock_loss", 3'b000, 1'b0, 1'b1, 8'd1);
    @(negedge CLK);
    pll_locked = 2'b11;
    ev = ev + 26;
    push_seq(ev, 1'b1, 8'd1, 99, "reseq_loss");
    wait_cyc(ev + 60);

    // Request in RUN clears fault but keeps the count; halt during the resequence.
    n = cyc;
    resetn_in = 1'b0;
    expect_at(n + 1, "req_keep_cnt", 3'b000, 1'b0, 1'b0, 8'd1);
    expect_at(n + 3, "req_keep_cnt2", 3'b000, 1'b0, 1'b0, 8'd1);
    wait_cyc(n + 3);
    resetn_in = 1'b1;
    ev = n + 5;
    expect_at(ev + 16, "halt_s0", 3'b001, 1'b0, 1'b0, 8'd1);
    expect_at(ev + 41, "halt_s1_late", 3'b001, 1'b0, 1'b0, 8'd1);
    expect_at(ev + 42, "halt_s1", 3'b011, 1'b0, 1'b0, 8'd1);
    expect_at(ev + 57, "halt_s2_late", 3'b011, 1'b0, 1'b0, 8'd1);
    expect_at(ev + 58, "halt_s2", 3'b111, 1'b1, 1'b0, 8'd1);
    wait_cyc(ev + 20);
    halt = 1'b1;
    wait_cyc(ev + 30);
    halt = 1'b0;
    wait_cyc(ev + 60);
    halt = 1'b1;
    expect_at(ev + 61, "run_halt_a", 3'b111, 1'b1, 1'b0, 8'd1);
    expect_at(ev + 64, "run_halt_b", 3'b111, 1'b1, 1'b0, 8'd1);
    expect_at(ev + 66, "run_halt_c", 3'b111, 1'b1, 1'b0, 8'd1);
    expect_at(ev + 70, "run_halt_d", 3'b111, 1'b1, 1'b0, 8'd1);
    wait_cyc(ev + 63);
    halt = 1'b0;
    wait_cyc(ev + 65);
    halt = 1'b1;
    @(negedge CLK);
    halt = 1'b0;
    wait_cyc(ev + 70);

    // Request and lock drop together: request wins, no count.
    n = cyc;
    resetn_in = 1'b0;
    pll_locked = 2'b00;
    expect_at(n + 1, "req_and_loss", 3'b000, 1'b0, 1'b0, 8'd1);
    @(negedge CLK);
    resetn_in = 1'b1;
    pll_locked = 2'b11;
    push_seq(n + 6, 1'b0, 8'd1, 99, "reseq_g");
    wait_cyc(n + 6 + 60);

    // 300 lock drops in RUN: count saturates at 255.
    for (int i = 0; i < 300; i++) begin
      n = cyc;
      cexp = (i + 2 > 255) ? 8'd255 : 8'(i + 2);
      pll_locked = 2'b10;
      expect_at(n + 1, "sat_loss", 3'b000, 1'b0, 1'b1, cexp);
      expect_at(n + 54, "sat_run", 3'b111, 1'b1, 1'b1, cexp);
      @(negedge CLK);
      pll_locked = 2'b11;
      wait_cyc(n + 54);
    end

    // Async reset mid-STRETCH, between edges.
    n = cyc;
    resetn_in = 1'b0;
    expect_at(n + 1, "pre_async_req", 3'b000, 1'b0, 1'b0, 8'd255);
    @(negedge CLK);
    resetn_in = 1'b1;
    ev = n + 3;
    push_seq(ev, 1'b0, 8'd255, 16, "pre_async");
    wait_cyc(ev + 20);
    #2;
    reset = 1'b1;
    #1;
    compare("async_reset", 3'b000, 1'b0, 1'b0, 8'd0);
    repeat (2) @(negedge CLK);
    reset = 1'b0;
    r = cyc;
    expect_at(r + 1, "restart_hold", 3'b000, 1'b0, 1'b0, 8'd0);
    push_seq(r + 5, 1'b0, 8'd0, 99, "restart");
    wait_cyc(r + 5 + 60);

    repeat (3) @(negedge CLK);
    foreach (sbq[i]) begin
      checks++;
      errors++;
      $display("FAIL %s: slot cyc=%0d never reached", sbq[i].name, sbq[i].at);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
